// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and constants for the multiply/divide unit
package muldiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam logic [MD_WIDTH-1:0] DIV0_QUOT = '1;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIXUP, S_DONE} state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one multiply add-shift or restoring-divide shift-subtract iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);
  logic [WIDTH:0] sum, rem_sh, diff;
  logic borrow;
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, opnd};
    borrow   = diff[WIDTH];
    acc_next = !is_div ? {sum, acc[WIDTH-1:1]}
             : borrow  ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
             :           {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: 34-cycle iterative mult/multu/div/divu sequencer driving {hi,lo}
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     srca,
  input  logic [WIDTH-1:0]     srcb,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output logic [2*WIDTH-1:0]   result
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic is_div, is_sgn, last;
  logic [WIDTH-1:0] ma, mb, quot, rem;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_next(acc_step)
  );
  always_comb begin
    is_div    = op_q inside {OP_DIV, OP_DIVU};
    is_sgn    = op_q inside {OP_MULT, OP_DIV};
    ma        = (is_sgn && a_q[WIDTH-1]) ? -a_q : a_q;
    mb        = (is_sgn && b_q[WIDTH-1]) ? -b_q : b_q;
    quot      = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];
    prod      = neg_res_q ? -acc_q : acc_q;
    last      = cnt_q == CW'(WIDTH-1);
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = start ? S_PREP : S_IDLE;
        op_d    = start ? op_e'(op) : op_q;
        a_d     = start ? srca : a_q;
        b_d     = start ? srcb : b_q;
      end
      S_PREP: begin
        acc_d     = {{WIDTH{1'b0}}, is_div ? ma : mb};
        opnd_d    = is_div ? mb : ma;
        neg_res_d = is_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem_d = is_sgn && a_q[WIDTH-1];
        cnt_d     = '0;
        state_d   = S_CALC;
      end
      S_CALC: begin
        acc_d   = acc_step;
        cnt_d   = last ? '0 : CW'(cnt_q + 1'b1);
        state_d = last ? S_FIXUP : S_CALC;
      end
      S_FIXUP: begin
        hi_d    = !is_div ? prod[2*WIDTH-1:WIDTH] : (b_q == '0) ? a_q : neg_rem_q ? -rem : rem;
        lo_d    = !is_div ? prod[WIDTH-1:0] : (b_q == '0) ? WIDTH'(DIV0_QUOT) : neg_res_q ? -quot : quot;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end
  assign busy   = state_q inside {S_PREP, S_CALC, S_FIXUP};
  assign done   = state_q == S_DONE;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign result = {hi_q, lo_q};
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset, start;
  logic [1:0] op;
  logic [31:0] srca, srcb, hi, lo;
  logic [63:0] result;
  logic busy, done;
  int pass_cnt = 0;
  int total = 0;
  int lat, bcnt;
  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .result(result)
  );
  always #5 clk = ~clk;
  task automatic issue_now(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0; srca = 32'h5A5A_5A5A; srcb = 32'hA5A5_A5A5;
    lat = 1; bcnt = busy ? 1 : 0;
  endtask
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue_now(o, a, b);
  endtask
  task automatic wait_done();
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
    total++; if (result !== 64'h0) $display("FAIL reset_result got=%h exp=0", result); else pass_cnt++;
    reset = 1'b0;
  endtask
  task automatic test_mult();
    issue(2'b00, 32'd7, 32'hFFFF_FFFD);
    wait_done();
    total++; if (lat !== 35) $display("FAIL mult_latency got=%0d exp=35", lat); else pass_cnt++;
    total++; if (bcnt !== 34) $display("FAIL mult_busy_cycles got=%0d exp=34", bcnt); else pass_cnt++;
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got=%h exp=ffffffff", hi); else pass_cnt++;
    total++; if (lo !== 32'hFFFF_FFEB) $display("FAIL mult_lo got=%h exp=ffffffeb", lo); else pass_cnt++;
    total++; if (result !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL mult_result got=%h exp=ffffffffffffffeb", result); else pass_cnt++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL mult_done_pulse got=%b exp=0", done); else pass_cnt++;
    total++; if (lo !== 32'hFFFF_FFEB) $display("FAIL mult_lo_hold got=%h exp=ffffffeb", lo); else pass_cnt++;
  endtask
  task automatic test_multu();
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    total++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got=%h exp=fffffffe", hi); else pass_cnt++;
    total++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo got=%h exp=00000001", lo); else pass_cnt++;
  endtask
  task automatic test_div();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got=%h exp=fffffffd", lo); else pass_cnt++;
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got=%h exp=ffffffff", hi); else pass_cnt++;
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_done();
    total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_negb_lo got=%h exp=fffffffd", lo); else pass_cnt++;
    total++; if (hi !== 32'h0000_0001) $display("FAIL div_negb_hi got=%h exp=00000001", hi); else pass_cnt++;
  endtask
  task automatic test_div_zero();
    issue(2'b11, 32'd100, 32'd0);
    wait_done();
    total++; if (lat !== 35) $display("FAIL div0_latency got=%0d exp=35", lat); else pass_cnt++;
    total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL div0_lo got=%h exp=ffffffff", lo); else pass_cnt++;
    total++; if (hi !== 32'h0000_0064) $display("FAIL div0_hi got=%h exp=00000064", hi); else pass_cnt++;
    issue(2'b10, 32'hFFFF_FFF0, 32'd0);
    wait_done();
    total++; if (hi !== 32'hFFFF_FFF0) $display("FAIL sdiv0_hi got=%h exp=fffffff0", hi); else pass_cnt++;
  endtask
  task automatic test_div_overflow();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    total++; if (lo !== 32'h8000_0000) $display("FAIL ovf_lo got=%h exp=80000000", lo); else pass_cnt++;
    total++; if (hi !== 32'h0) $display("FAIL ovf_hi got=%h exp=00000000", hi); else pass_cnt++;
  endtask
  task automatic test_start_while_busy();
    issue(2'b01, 32'd3, 32'd5);
    repeat (3) begin @(negedge clk); lat++; end
    start = 1'b1; op = 2'b11; srca = 32'd9; srcb = 32'd0;
    @(negedge clk); lat++;
    start = 1'b0;
    total++; if (hi !== 32'h0) $display("FAIL busy_hi_stable got=%h exp=00000000", hi); else pass_cnt++;
    wait_done();
    total++; if (lat !== 35) $display("FAIL ignore_latency got=%0d exp=35", lat); else pass_cnt++;
    total++; if (lo !== 32'd15) $display("FAIL ignore_lo got=%h exp=0000000f", lo); else pass_cnt++;
    total++; if (hi !== 32'd0) $display("FAIL ignore_hi got=%h exp=00000000", hi); else pass_cnt++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL ignore_no_restart got=%b exp=0", busy); else pass_cnt++;
  endtask
  task automatic test_back_to_back();
    issue(2'b01, 32'd6, 32'd7);
    wait_done();
    total++; if (lo !== 32'd42) $display("FAIL b2b_first_lo got=%h exp=0000002a", lo); else pass_cnt++;
    issue_now(2'b11, 32'd100, 32'd7);
    total++; if (busy !== 1'b1) $display("FAIL b2b_no_gap got=%b exp=1", busy); else pass_cnt++;
    wait_done();
    total++; if (lat !== 35) $display("FAIL b2b_latency got=%0d exp=35", lat); else pass_cnt++;
    total++; if (lo !== 32'd14) $display("FAIL b2b_lo got=%h exp=0000000e", lo); else pass_cnt++;
    total++; if (hi !== 32'd2) $display("FAIL b2b_hi got=%h exp=00000002", hi); else pass_cnt++;
  endtask
  task automatic test_reset_mid();
    int done_seen;
    issue(2'b00, 32'd11, 32'd13);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else pass_cnt++;
    total++; if (result !== 64'h0) $display("FAIL rmid_result got=%h exp=0", result); else pass_cnt++;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    total++; if (done_seen !== 0) $display("FAIL rmid_no_done got=%0d exp=0", done_seen); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_div_overflow();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that executes MIPS mult, multu, div and divu.
- Sits beside the ALU and drives the 64-bit {hi,lo} write value into the hi/lo special-register stage.
- The control path stalls on busy.
- Replaces the single-cycle 64-bit ALU product with a 34-cycle shift/add and restoring-divide sequencer.

Parameters:
- WIDTH, 32, operand width; hi and lo are WIDTH each; result is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- op  input  2  00 mult, 01 multu, 10 div, 11 divu
- srca  input  WIDTH  rs operand (multiplicand / dividend)
- srcb  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  high in PREP, CALC, FIXUP
- done  output  1  one-cycle pulse in DONE
- hi  output  WIDTH  high product word or remainder
- lo  output  WIDTH  low product word or quotient
- result  output  2*WIDTH  {hi,lo}, fed to the hi/lo write path

Behaviour:
- Reset, including mid-operation:
  - state=IDLE, busy=0, done=0, hi=lo=0, iteration counter=0.
  - Any in-flight operation is discarded; no done is issued for it.
- States: IDLE, PREP, CALC, FIXUP, DONE.
- IDLE:
  - start=1 latches op, srca, srcb and moves to PREP.
  - start=0 holds IDLE.
- PREP (1 cycle):
  - Signed ops: take magnitudes of the operands; record result sign = sign(a) xor sign(b) and remainder sign = sign(a).
  - Unsigned ops: pass operands through; both signs = 0.
  - Clear the accumulator and set counter=0, then go to CALC.
- CALC (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: if multiplier lsb=1, add the multiplicand into the upper accumulator half with carry-out kept; then shift the {carry,acc} right by 1.
  - Divide: shift {rem,quot} left by 1; trial-subtract the divisor from rem; if there is no borrow, commit the difference and set quot lsb=1.
  - Counter wraps at WIDTH-1 and moves to FIXUP.
- FIXUP (1 cycle):
  - Apply two's-complement negation per the recorded signs and write hi/lo.
  - Division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero (srcb=0, any div op): lo=all ones, hi=dividend as latched. Uniform latency, no exception.
  - Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- DONE (1 cycle):
  - done=1, busy=0.
  - start=1 goes directly to PREP (back-to-back issue); otherwise go to IDLE.
- Latency: with start sampled at edge E0, done=1 in the cycle after E34 and hi/lo are valid from that cycle on.
- hi/lo hold their value until the next FIXUP write or reset; they never change while busy.
- start while busy is ignored; operands are not re-latched.
- Operand inputs may change freely after E0.
- op is decoded only at latch time.

Decomposition:
- Shared package muldiv_pkg holds:
  - op enum: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum
  - WIDTH default constant
  - DIV0_QUOT constant (all ones)
- Sub-module muldiv_step (combinational): one iteration of either the multiply add-shift or the divide shift-subtract, selected by an is_div input. The top level owns the registers, counter and FSM.

Test Plan:
- mult 7 x 0xFFFFFFFD -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy for 34 cycles then done pulses exactly one cycle.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Control sequence, in order:
  - Pulse start again at cycle 5 of a busy op -> ignored; original result intact.
  - Start in the DONE cycle -> next op begins with no IDLE gap.
  - Assert reset during CALC -> next cycle busy=0, hi=lo=0, and no done pulse.
